// File: rtl/id_hazard_stage.sv
// id_hazard_stage: decode-stage hazard/bubble controller in front of the ID/EX register.
// Squashes on load-use hazards and taken branches, and counts bubble cycles.
`default_nettype none

module id_hazard_stage #(
  parameter int LOAD_STALL   = 1,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [16:0]      ctrl_in,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic [4:0]       ex_rd,
  input  logic             ex_load,
  input  logic             ex_rf_enable,
  input  logic             branch_taken,
  output logic [16:0]      control_signals,
  output logic             pc_le,
  output logic             ifid_le,
  output logic             ifid_clr,
  output logic             stalled,
  output logic [CNT_W-1:0] bubble_count
);

  localparam int MAXC = (LOAD_STALL > FLUSH_CYCLES) ? LOAD_STALL : FLUSH_CYCLES;
  localparam int CW   = (MAXC < 2) ? 1 : $clog2(MAXC + 1);

  localparam logic [CW-1:0]    CNT_ONE    = CW'(1);
  localparam logic [CW-1:0]    STALL_LOAD = CW'(LOAD_STALL - 1);
  localparam logic [CW-1:0]    FLUSH_LOAD = CW'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] BC_ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          hz;
  logic          bubble;

  assign hz = ex_load & ex_rf_enable & (ex_rd != 5'd0) &
              ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));

  always_comb begin
    state_nx        = state;
    cnt_nx          = cnt;
    control_signals = ctrl_in;
    pc_le           = 1'b1;
    ifid_le         = 1'b1;
    ifid_clr        = 1'b0;
    stalled         = 1'b0;
    bubble          = 1'b0;

    if (reset) begin
      control_signals = '0;
      pc_le           = 1'b0;
      ifid_le         = 1'b0;
      state_nx        = RUN;
      cnt_nx          = '0;
    end else if (branch_taken) begin
      // A taken branch overrides any stall in progress and restarts the squash window.
      control_signals = '0;
      ifid_clr        = 1'b1;
      bubble          = 1'b1;
      if (FLUSH_CYCLES == 1) begin
        state_nx = RUN;
        cnt_nx   = '0;
      end else begin
        state_nx = FLUSH;
        cnt_nx   = FLUSH_LOAD;
      end
    end else begin
      case (state)
        RUN: begin
          if (hz) begin
            control_signals = '0;
            pc_le           = 1'b0;
            ifid_le         = 1'b0;
            bubble          = 1'b1;
            if (LOAD_STALL == 1) begin
              state_nx = RUN;
              cnt_nx   = '0;
            end else begin
              state_nx = STALL;
              cnt_nx   = STALL_LOAD;
            end
          end
        end
        STALL: begin
          control_signals = '0;
          pc_le           = 1'b0;
          ifid_le         = 1'b0;
          stalled         = 1'b1;
          bubble          = 1'b1;
          cnt_nx          = cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state_nx = RUN;
          end
        end
        FLUSH: begin
          control_signals = '0;
          ifid_clr        = 1'b1;
          bubble          = 1'b1;
          cnt_nx          = cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state_nx = RUN;
          end
        end
        default: begin
          state_nx = RUN;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bubble_count <= '0;
    end else if (bubble && (bubble_count != {CNT_W{1'b1}})) begin
      bubble_count <= bubble_count + BC_ONE;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_id_hazard_stage.sv
// tb_id_hazard_stage: directed and randomized checks of id_hazard_stage against a
// cycle-level model that tracks the number of pending bubble cycles.
`default_nettype none

module tb_id_hazard_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [16:0] ctrl_in;
  logic [4:0]  id_rs, id_rt, ex_rd;
  logic        id_uses_rt, ex_load, ex_rf_enable, branch_taken;

  logic [16:0] cs_a, cs_b;
  logic        pc_a, pc_b, le_a, le_b, clr_a, clr_b, st_a, st_b;
  logic [15:0] bc_a;
  logic [3:0]  bc_b;

  int total  = 0;
  int passed = 0;

  // Reference model state, index 0 = default DUT, index 1 = LOAD_STALL=3/CNT_W=4 DUT
  int pend [2];
  bit kfl  [2];
  int bcm  [2];
  int LS   [2] = '{1, 3};
  int FC   [2] = '{2, 2};
  int BMAX [2] = '{65535, 15};

  always #5 clk = ~clk;

  id_hazard_stage #(.LOAD_STALL(1), .FLUSH_CYCLES(2), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .ctrl_in(ctrl_in), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .ex_rd(ex_rd), .ex_load(ex_load), .ex_rf_enable(ex_rf_enable),
    .branch_taken(branch_taken), .control_signals(cs_a), .pc_le(pc_a), .ifid_le(le_a),
    .ifid_clr(clr_a), .stalled(st_a), .bubble_count(bc_a)
  );

  id_hazard_stage #(.LOAD_STALL(3), .FLUSH_CYCLES(2), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .ctrl_in(ctrl_in), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .ex_rd(ex_rd), .ex_load(ex_load), .ex_rf_enable(ex_rf_enable),
    .branch_taken(branch_taken), .control_signals(cs_b), .pc_le(pc_b), .ifid_le(le_b),
    .ifid_clr(clr_b), .stalled(st_b), .bubble_count(bc_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic bit hz_ref();
    if (!(ex_load && ex_rf_enable) || ex_rd == 5'd0) return 1'b0;
    return (ex_rd == id_rs) || (id_uses_rt && ex_rd == id_rt);
  endfunction

  // Whether model k forces a bubble this cycle with the current inputs
  function automatic bit bubble_ref(input int k);
    if (reset) return 1'b0;
    return branch_taken || pend[k] > 0 || hz_ref();
  endfunction

  task automatic check_k(input int k, input string nm, input logic [16:0] cs,
                         input logic pc, input logic le, input logic clr,
                         input logic st, input logic [31:0] bc);
    logic [16:0] e_cs;
    logic        e_pc, e_le, e_clr, e_st;
    if (reset) begin
      pend[k] = 0;
      bcm[k]  = 0;
      e_cs = '0; e_pc = 0; e_le = 0; e_clr = 0; e_st = 0;
    end else if (branch_taken || (pend[k] > 0 && kfl[k])) begin
      e_cs = '0; e_pc = 1; e_le = 1; e_clr = 1; e_st = 0;
    end else if (pend[k] > 0) begin
      e_cs = '0; e_pc = 0; e_le = 0; e_clr = 0; e_st = 1;
    end else if (hz_ref()) begin
      e_cs = '0; e_pc = 0; e_le = 0; e_clr = 0; e_st = 0;
    end else begin
      e_cs = ctrl_in; e_pc = 1; e_le = 1; e_clr = 0; e_st = 0;
    end
    chk({nm, "_ctrl"}, 32'(cs), 32'(e_cs));
    chk({nm, "_pc_le"}, 32'(pc), 32'(e_pc));
    chk({nm, "_ifid_le"}, 32'(le), 32'(e_le));
    chk({nm, "_ifid_clr"}, 32'(clr), 32'(e_clr));
    if (!branch_taken) chk({nm, "_stalled"}, 32'(st), 32'(e_st));
    chk({nm, "_bcount"}, bc, 32'(bcm[k]));
  endtask

  task automatic advance_k(input int k, input bit bub, input bit hz);
    if (reset) begin
      pend[k] = 0;
      bcm[k]  = 0;
    end else begin
      if (bub && bcm[k] < BMAX[k]) bcm[k]++;
      if (branch_taken) begin
        pend[k] = FC[k] - 1;
        kfl[k]  = 1'b1;
      end else if (pend[k] > 0) begin
        pend[k]--;
      end else if (hz) begin
        pend[k] = LS[k] - 1;
        kfl[k]  = 1'b0;
      end
    end
  endtask

  // One clock: compare combinational outputs mid-cycle, then advance the model at the edge.
  task automatic step();
    bit b0, b1, h;
    @(negedge clk);
    check_k(0, "a", cs_a, pc_a, le_a, clr_a, st_a, 32'(bc_a));
    check_k(1, "b", cs_b, pc_b, le_b, clr_b, st_b, 32'(bc_b));
    b0 = bubble_ref(0);
    b1 = bubble_ref(1);
    h  = hz_ref();
    @(posedge clk);
    advance_k(0, b0, h);
    advance_k(1, b1, h);
    #1;
  endtask

  task automatic idle_inputs();
    ctrl_in      = 17'($urandom);
    id_rs        = 5'd1;
    id_rt        = 5'd2;
    id_uses_rt   = 1'b1;
    ex_rd        = 5'd3;
    ex_load      = 1'b0;
    ex_rf_enable = 1'b0;
    branch_taken = 1'b0;
  endtask

  initial begin
    int b0;
    for (int k = 0; k < 2; k++) begin
      pend[k] = 0; kfl[k] = 0; bcm[k] = 0;
    end
    reset = 1'b1;
    idle_inputs();
    step();
    reset = 1'b0;

    // Load-use hazard on rs
    ctrl_in = 17'h1ABCD; ex_load = 1; ex_rf_enable = 1; ex_rd = 5'd5; id_rs = 5'd5;
    step();
    chk("t1_bcount_after_hazard", 32'(bc_a), 32'd1);
    ex_load = 0;
    step();
    step(); step(); step();

    // r0 destination and unused rt never stall
    idle_inputs();
    ex_load = 1; ex_rf_enable = 1; ex_rd = 5'd0; id_rs = 5'd0;
    step();
    id_uses_rt = 0; ex_rd = 5'd7; id_rt = 5'd7; id_rs = 5'd1;
    step();

    // Single-cycle taken branch squashes two cycles
    idle_inputs();
    b0 = int'(bc_a);
    branch_taken = 1;
    step();
    branch_taken = 0;
    step();
    chk("t3_bcount_plus2", 32'(bc_a), 32'(b0 + 2));
    step();

    // Branch during second stall cycle of the 3-cycle stall
    ex_load = 1; ex_rf_enable = 1; ex_rd = 5'd4; id_rs = 5'd4;
    step();
    ex_load = 0;
    step();
    branch_taken = 1;
    #1;
    chk("t4_pc_le_on_branch", 32'(pc_b), 32'd1);
    step();
    branch_taken = 0;
    #1;
    chk("t4_stalled_after_branch", 32'(st_b), 32'd0);
    step();
    step();

    // Asynchronous reset in the middle of a flush
    branch_taken = 1;
    step();
    branch_taken = 0;
    #2;
    reset = 1;
    #1;
    chk("t5_ctrl_in_reset", 32'(cs_a), 32'd0);
    chk("t5_pc_le_in_reset", 32'(pc_a), 32'd0);
    chk("t5_bcount_in_reset", 32'(bc_b), 32'd0);
    step();
    reset = 0;
    ctrl_in = 17'h0F0F0;
    step();

    // Saturation of the 4-bit counter
    branch_taken = 1;
    for (int i = 0; i < 20; i++) step();
    chk("t6_bcount_saturated", 32'(bc_b), 32'hF);
    branch_taken = 0;
    step(); step();

    // Randomized traffic with narrow register range to provoke hazards
    for (int i = 0; i < 400; i++) begin
      ctrl_in      = 17'($urandom);
      id_rs        = 5'($urandom_range(0, 3));
      id_rt        = 5'($urandom_range(0, 3));
      ex_rd        = 5'($urandom_range(0, 3));
      id_uses_rt   = 1'($urandom);
      ex_load      = ($urandom_range(0, 2) != 0);
      ex_rf_enable = ($urandom_range(0, 3) != 0);
      branch_taken = ($urandom_range(0, 9) == 0);
      reset        = ($urandom_range(0, 49) == 0);
      step();
    end
    reset = 0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
